pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg_pkg.sv | 28 ++
 rtl/pipe_stage_reg.sv | 128 ++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline package: stage state encoding, bubble constant and helpers.
`default_nettype none

package pipe_stage_reg_pkg;

  // Maximum live entries any pipeline stage can hold (main + skid).
  localparam int C_PIPE_STAGE_MAX_OCC = 2;

  // Bit replicated to form the default bubble payload of a stage.
  localparam logic C_BUBBLE_BIT = 1'b0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_MAIN  = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

  function automatic logic [1:0] occ_of(input pipe_state_e st);
    case (st)
      ST_MAIN: occ_of = 2'd1;
      ST_FULL: occ_of = 2'd2;
      default: occ_of = 2'd0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module   : pipe_stage_reg
// Brief    : valid/ready pipeline stage register with flush; 1-entry by
//            default, 2-entry registered-ready skid mode when
//            PIPE_STAGE_SKID_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int            DW         = 64,
  parameter logic [DW-1:0] BUBBLE_VAL = {DW{C_BUBBLE_BIT}}
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occupancy
);

  pipe_state_e   r_state;
  pipe_state_e   w_state_nxt;
  logic [DW-1:0] r_main;
  logic [DW-1:0] w_main_nxt;
  logic          w_accept;
  logic          w_consume;

  assign w_accept  = in_valid && in_ready && !flush_i;
  assign w_consume = out_valid && out_ready && !flush_i;

  assign out_valid = (r_state != ST_EMPTY);
  assign out_data  = r_main;

`ifdef PIPE_STAGE_SKID_EN
  logic [DW-1:0] r_skid;
  logic [DW-1:0] w_skid_nxt;
  logic          r_in_ready;

  // Registered ready breaks the out_ready -> in_ready combinational path.
  assign in_ready  = r_in_ready;
  assign occupancy = occ_of(r_state);
`else
  assign in_ready  = (r_state == ST_EMPTY) || out_ready;
  assign occupancy = {1'b0, (r_state != ST_EMPTY)};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
`ifdef PIPE_STAGE_SKID_EN
    w_skid_nxt  = r_skid;
`endif
    if (flush_i) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = BUBBLE_VAL;
`ifdef PIPE_STAGE_SKID_EN
      w_skid_nxt  = BUBBLE_VAL;
`endif
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_nxt = ST_MAIN;
            w_main_nxt  = in_data;
          end
        end
        ST_MAIN: begin
          if (w_accept && w_consume) begin
            w_main_nxt = in_data;
`ifdef PIPE_STAGE_SKID_EN
          end else if (w_accept) begin
            w_state_nxt = ST_FULL;
            w_skid_nxt  = in_data;
`endif
          end else if (w_consume) begin
            w_state_nxt = ST_EMPTY;
            w_main_nxt  = BUBBLE_VAL;
          end
        end
`ifdef PIPE_STAGE_SKID_EN
        ST_FULL: begin
          if (w_consume) begin
            w_state_nxt = ST_MAIN;
            w_main_nxt  = r_skid;
            w_skid_nxt  = BUBBLE_VAL;
          end
        end
`endif
        default: begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = BUBBLE_VAL;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_main  <= BUBBLE_VAL;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_skid     <= BUBBLE_VAL;
      r_in_ready <= 1'b1;
    end else begin
      r_skid     <= w_skid_nxt;
      r_in_ready <= (w_state_nxt != ST_FULL);
    end
  end
`endif

endmodule

`default_nettype wire
